// File: rtl/serv_rf_ser_pkg.sv
// Shared types and constants for the register-file operand serializer.
package serv_rf_ser_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned CNT_W    = 5;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(31);

    typedef enum logic [2:0] {
        IDLE,
        RD1,
        RD2,
        SHIFT,
        WB
    } state_t;

endpackage

// File: rtl/serv_rf_ser_sreg.sv
// Word register with parallel load and LSB-first serial shift (serial-in at MSB).
module serv_rf_ser_sreg #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_shift,
    input  logic         i_sin,
    output logic [W-1:0] o_q,
    output logic         o_sout
);

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            o_q <= '0;
        end else if (i_load) begin
            o_q <= i_data;
        end else if (i_shift) begin
            o_q <= {i_sin, o_q[W-1:1]};
        end
    end

    assign o_sout = o_q[0];

endmodule

// File: rtl/serv_rf_ser.sv
// Fetches rs1/rs2 from the RF RAM, streams them bit-serially to the ALU and writes the
// serial result back to rd. Optional parity generation/checking under SERV_RF_PARITY_EN.
module serv_rf_ser
    import serv_rf_ser_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF,
    parameter int unsigned AW   = AW_DEF
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [AW-1:0]   i_rs1_addr,
    input  logic [AW-1:0]   i_rs2_addr,
    input  logic [AW-1:0]   i_rd_addr,
    input  logic            i_rd_en,
    output logic            o_rf_req,
    output logic            o_rf_we,
    output logic [AW-1:0]   o_rf_addr,
    output logic [XLEN-1:0] o_rf_wdata,
    output logic            o_rf_wpar,
    input  logic [XLEN-1:0] i_rf_rdata,
    input  logic            i_rf_rpar,
    input  logic            i_rf_ack,
    output logic            o_en,
    output logic            o_init,
    output logic            o_cnt_done,
    output logic            o_rs1,
    output logic            o_rs2,
    input  logic            i_rd,
    output logic            o_done,
    output logic            o_par_err
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [AW-1:0]    rs1_addr;
    logic [AW-1:0]    rs2_addr;
    logic [AW-1:0]    rd_addr;
    logic             rd_en;
    logic             done_q;

    logic             ld_rs1;
    logic             ld_rs2;
    logic             shift_en;
    logic             acc_done;
    logic [XLEN-1:0]  ld_data;
    logic [XLEN-1:0]  rd_word;
    logic [XLEN-1:0]  rs1_q_unused;
    logic [XLEN-1:0]  rs2_q_unused;
    logic             rs1_bit;
    logic             rs2_bit;

    // RAM port, load strobes and serial framing decoded from the current state
    always_comb begin
        o_rf_req   = 1'b0;
        o_rf_we    = 1'b0;
        o_rf_addr  = '0;
        o_rf_wdata = '0;
        o_en       = 1'b0;
        o_init     = 1'b0;
        o_cnt_done = 1'b0;
        ld_rs1     = 1'b0;
        ld_rs2     = 1'b0;
        shift_en   = 1'b0;
        acc_done   = 1'b0;
        ld_data    = i_rf_rdata;
        case (state)
            RD1: begin
                if (rs1_addr == '0) begin
                    ld_rs1   = 1'b1;
                    ld_data  = '0;
                    acc_done = 1'b1;
                end else begin
                    o_rf_req  = 1'b1;
                    o_rf_addr = rs1_addr;
                    ld_rs1    = i_rf_ack;
                    acc_done  = i_rf_ack;
                end
            end
            RD2: begin
                if (rs2_addr == '0) begin
                    ld_rs2   = 1'b1;
                    ld_data  = '0;
                    acc_done = 1'b1;
                end else begin
                    o_rf_req  = 1'b1;
                    o_rf_addr = rs2_addr;
                    ld_rs2    = i_rf_ack;
                    acc_done  = i_rf_ack;
                end
            end
            SHIFT: begin
                o_en       = 1'b1;
                o_init     = (cnt == '0);
                o_cnt_done = (cnt == CNT_LAST);
                shift_en   = 1'b1;
            end
            WB: begin
                o_rf_req   = 1'b1;
                o_rf_we    = 1'b1;
                o_rf_addr  = rd_addr;
                o_rf_wdata = rd_word;
                acc_done   = i_rf_ack;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= IDLE;
            cnt      <= '0;
            rs1_addr <= '0;
            rs2_addr <= '0;
            rd_addr  <= '0;
            rd_en    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        rs1_addr <= i_rs1_addr;
                        rs2_addr <= i_rs2_addr;
                        rd_addr  <= i_rd_addr;
                        rd_en    <= i_rd_en;
                        state    <= RD1;
                    end
                end
                RD1: if (acc_done) state <= RD2;
                RD2: begin
                    if (acc_done) begin
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        if (rd_en && (rd_addr != '0)) begin
                            state <= WB;
                        end else begin
                            state  <= IDLE;
                            done_q <= 1'b1;
                        end
                    end
                end
                WB: begin
                    if (acc_done) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    serv_rf_ser_sreg #(.W(XLEN)) u_rs1 (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_load (ld_rs1),
        .i_data (ld_data),
        .i_shift(shift_en),
        .i_sin  (1'b0),
        .o_q    (rs1_q_unused),
        .o_sout (rs1_bit)
    );

    serv_rf_ser_sreg #(.W(XLEN)) u_rs2 (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_load (ld_rs2),
        .i_data (ld_data),
        .i_shift(shift_en),
        .i_sin  (1'b0),
        .o_q    (rs2_q_unused),
        .o_sout (rs2_bit)
    );

    // Result register fills from the MSB so the word is aligned after 32 shifts
    serv_rf_ser_sreg #(.W(XLEN)) u_rd (
        .clk    (clk),
        .i_rst  (i_rst),
        .i_load (1'b0),
        .i_data ('0),
        .i_shift(shift_en),
        .i_sin  (i_rd),
        .o_q    (rd_word),
        .o_sout ()
    );

    assign o_rs1  = o_en & rs1_bit;
    assign o_rs2  = o_en & rs2_bit;
    assign o_done = done_q;

`ifdef SERV_RF_PARITY_EN
    logic par_err;
    logic rd_acc;

    assign rd_acc = o_rf_req & ~o_rf_we & i_rf_ack;

    // Sticky until the next accepted start; the transaction itself is not disturbed
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            par_err <= 1'b0;
        end else if ((state == IDLE) && i_start) begin
            par_err <= 1'b0;
        end else if (rd_acc && ((^i_rf_rdata) != i_rf_rpar)) begin
            par_err <= 1'b1;
        end
    end

    assign o_rf_wpar = ^o_rf_wdata;
    assign o_par_err = par_err;
`else
    logic rpar_unused;

    assign rpar_unused = i_rf_rpar;
    assign o_rf_wpar   = 1'b0;
    assign o_par_err   = 1'b0;
`endif

endmodule
